// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-to-1 selector.
//   sel_width(n) : select width for n inputs (ceil log2, never below 1)
//   MUX_MAX_IN   : largest supported input count
//   bufState_e   : occupancy of the 2-entry output skid buffer
package mux_pkg;

    localparam int unsigned MUX_MAX_IN = 16;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } bufState_e;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry valid/ready FIFO buffer with registered ready.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/in_valid    : producer side, in_ready = not full
//   out_data/out_valid  : head entry, out_valid = not empty
//   out_ready           : consumer accepts the head entry
module mux_skid_buf
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    bufState_e        state, stateNext;
    logic [WIDTH-1:0] headQ, tailQ;
    logic             push, pop;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (state != BUF_FULL);
    assign out_valid = (state != BUF_EMPTY);
    assign out_data  = headQ;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        stateNext = state;
        case (state)
            BUF_EMPTY: if (push) stateNext = BUF_ONE;
            BUF_ONE: begin
                if (push && !pop)      stateNext = BUF_FULL;
                else if (!push && pop) stateNext = BUF_EMPTY;
            end
            BUF_FULL:  if (pop) stateNext = BUF_ONE;
            default:   stateNext = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BUF_EMPTY;
            headQ <= '0;
            tailQ <= '0;
        end else begin
            state <= stateNext;
            // Head refills from the tail on a pop when full, otherwise
            // directly from the input when the buffer is (or becomes) empty.
            if (state == BUF_FULL && pop)
                headQ <= tailQ;
            else if (push && (state == BUF_EMPTY || pop))
                headQ <= in_data;
            if (push && state == BUF_ONE && !pop)
                tailQ <= in_data;
        end
    end

endmodule

// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 selector with latched select, valid/ready flow control,
// sticky illegal-select flag and a 2-entry output skid buffer.
//   sel_load/sel_in     : load select register (bypassed to same-cycle transfer)
//   in_data             : NUM_IN words, input i at [i*WIDTH +: WIDTH]
//   in_valid/in_ready   : producer handshake
//   out_data/out_valid  : buffered selected word, out_ready from consumer
//   sel_cur             : current latched select
//   err_sel/err_clr     : sticky illegal-select flag and its clear
module mux_nto1_reg
    import mux_pkg::*;
#(
    parameter int unsigned     WIDTH       = 5,
    parameter int unsigned     NUM_IN      = 4,
    parameter int unsigned     SEL_W       = mux_pkg::sel_width(NUM_IN),
    parameter bit              LOCK_SEL    = 1'b1,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sel_load,
    input  logic [SEL_W-1:0]        sel_in,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        sel_cur,
    output logic                    err_sel,
    input  logic                    err_clr
);

    localparam int unsigned CMP_W = SEL_W + 1;

    logic [SEL_W-1:0] selQ, effSel;
    logic [WIDTH-1:0] muxWord, pushWord;
    logic             selIllegal, accept, errQ;

    always_comb begin
        if (LOCK_SEL)
            effSel = sel_load ? sel_in : selQ;
        else
            effSel = sel_in;
    end

    // Extra bit keeps the compare correct when NUM_IN == 2**SEL_W.
    assign selIllegal = ({1'b0, effSel} >= CMP_W'(NUM_IN));

    always_comb begin
        muxWord = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (effSel == SEL_W'(i))
                muxWord = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign pushWord = selIllegal ? DEFAULT_VAL : muxWord;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selQ <= '0;
            errQ <= 1'b0;
        end else begin
            if (sel_load)
                selQ <= sel_in;
            // A new illegal accept outranks a simultaneous clear.
            if (accept && selIllegal)
                errQ <= 1'b1;
            else if (err_clr)
                errQ <= 1'b0;
        end
    end

    assign sel_cur = selQ;
    assign err_sel = errQ;

    mux_skid_buf #(
        .WIDTH(WIDTH)
    ) uBuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (pushWord),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Three instances share one stimulus stream:
//   0: defaults (NUM_IN=4, LOCK_SEL=1)
//   1: NUM_IN=3, DEFAULT_VAL=0x15
//   2: NUM_IN=4, LOCK_SEL=0
module tb_mux_nto1_reg;

    logic        clk = 1'b0;
    logic        rstN;
    logic        selLoad, inValid, outReady, errClr;
    logic [1:0]  selIn;
    logic [19:0] inData;

    logic [2:0]      inReady, outValid, errSel;
    logic [2:0][4:0] outData;
    logic [2:0][1:0] selCur;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int unsigned nIn  [3] = '{4, 3, 4};
    bit          lock [3] = '{1'b1, 1'b1, 1'b0};
    logic [4:0]  defv [3] = '{5'h00, 5'h15, 5'h00};
    logic [4:0]  mbuf [3][2];
    int          mcnt [3];
    int unsigned mSel [3];
    bit          mErr [3];

    always #5 clk = ~clk;

    mux_nto1_reg dutA (
        .clk(clk), .rst_n(rstN), .sel_load(selLoad), .sel_in(selIn),
        .in_data(inData), .in_valid(inValid), .in_ready(inReady[0]),
        .out_data(outData[0]), .out_valid(outValid[0]), .out_ready(outReady),
        .sel_cur(selCur[0]), .err_sel(errSel[0]), .err_clr(errClr)
    );

    mux_nto1_reg #(.NUM_IN(3), .DEFAULT_VAL(5'h15)) dutB (
        .clk(clk), .rst_n(rstN), .sel_load(selLoad), .sel_in(selIn),
        .in_data(inData[14:0]), .in_valid(inValid), .in_ready(inReady[1]),
        .out_data(outData[1]), .out_valid(outValid[1]), .out_ready(outReady),
        .sel_cur(selCur[1]), .err_sel(errSel[1]), .err_clr(errClr)
    );

    mux_nto1_reg #(.LOCK_SEL(1'b0)) dutC (
        .clk(clk), .rst_n(rstN), .sel_load(selLoad), .sel_in(selIn),
        .in_data(inData), .in_valid(inValid), .in_ready(inReady[2]),
        .out_data(outData[2]), .out_valid(outValid[2]), .out_ready(outReady),
        .sel_cur(selCur[2]), .err_sel(errSel[2]), .err_clr(errClr)
    );

    task automatic chk(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0h want %0h t=%0t", name, k, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0;
            mSel[k] = 0;
            mErr[k] = 1'b0;
        end
    endtask

    // One clock of the specification's rules, using the inputs seen at the edge.
    task automatic modelStep();
        for (int k = 0; k < 3; k++) begin
            int unsigned es;
            bit          push, pop;
            logic [4:0]  w;
            es   = lock[k] ? (selLoad ? selIn : mSel[k]) : selIn;
            push = inValid && (mcnt[k] != 2);
            pop  = outReady && (mcnt[k] != 0);
            w    = (es < nIn[k]) ? inData[es*5 +: 5] : defv[k];
            if (pop) begin
                mbuf[k][0] = mbuf[k][1];
                mcnt[k]--;
            end
            if (push) begin
                mbuf[k][mcnt[k]] = w;
                mcnt[k]++;
            end
            if (push && es >= nIn[k]) mErr[k] = 1'b1;
            else if (errClr)          mErr[k] = 1'b0;
            if (selLoad) mSel[k] = selIn;
        end
    endtask

    task automatic compareAll();
        for (int k = 0; k < 3; k++) begin
            chk("in_ready", k, inReady[k], mcnt[k] != 2);
            chk("out_valid", k, outValid[k], mcnt[k] != 0);
            if (mcnt[k] != 0) chk("out_data", k, outData[k], mbuf[k][0]);
            chk("sel_cur", k, selCur[k], mSel[k]);
            chk("err_sel", k, errSel[k], mErr[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareAll();
    endtask

    task automatic checkResetValues();
        for (int k = 0; k < 3; k++) begin
            chk("rst_out_valid", k, outValid[k], 0);
            chk("rst_in_ready", k, inReady[k], 1);
            chk("rst_out_data", k, outData[k], 0);
            chk("rst_err_sel", k, errSel[k], 0);
            chk("rst_sel_cur", k, selCur[k], 0);
        end
    endtask

    localparam logic [19:0] BASE_DATA = {5'h11, 5'h0A, 5'h1F, 5'h03};

    initial begin
        rstN = 1'b0; selLoad = 0; selIn = 0; inValid = 0; outReady = 1;
        errClr = 0; inData = BASE_DATA;
        modelReset();
        #1 checkResetValues();
        @(negedge clk); @(negedge clk);
        rstN = 1'b1;

        // Latched select 2 then three transfers
        selLoad = 1; selIn = 2; inValid = 0;
        step();
        chk("lit_sel_cur2", 0, selCur[0], 2);
        selLoad = 0; inValid = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lit_sel2_valid", 0, outValid[0], 1);
            chk("lit_sel2_data", 0, outData[0], 5'h0A);
        end
        inValid = 0;
        step();

        // Same-cycle load bypass
        selLoad = 1; selIn = 1; inValid = 1;
        step();
        chk("lit_bypass_data", 0, outData[0], 5'h1F);
        chk("lit_bypass_sel", 0, selCur[0], 1);

        // Illegal select on the 3-input instance
        selLoad = 1; selIn = 3; inValid = 1;
        step();
        chk("lit_illegal_data", 1, outData[1], 5'h15);
        chk("lit_illegal_err", 1, errSel[1], 1);
        chk("lit_legal_sel3", 0, outData[0], 5'h11);
        selLoad = 0; errClr = 1;
        step();
        chk("lit_set_wins", 1, errSel[1], 1);
        inValid = 0;
        step();
        chk("lit_clear", 1, errSel[1], 0);
        errClr = 0;
        step();

        // Backpressure: ordering and registered ready
        selLoad = 1; selIn = 0; outReady = 0; inValid = 1;
        inData[4:0] = 5'd1; step();
        inData[4:0] = 5'd2; step();
        chk("lit_full_ready", 0, inReady[0], 0);
        inData[4:0] = 5'd3; step();
        chk("lit_hold_data", 0, outData[0], 5'd1);
        chk("lit_hold_ready", 0, inReady[0], 0);
        outReady = 1; step();
        chk("lit_pop1_data", 0, outData[0], 5'd2);
        chk("lit_pop1_ready", 0, inReady[0], 1);
        step();
        chk("lit_word3", 0, outData[0], 5'd3);
        inValid = 0; step();
        step();

        // Unlocked select toggling at full rate
        selLoad = 0; inData = BASE_DATA; inValid = 1; outReady = 1;
        for (int i = 0; i < 8; i++) begin
            selIn = 2'(i % 2);
            step();
            chk("lit_toggle", 2, outData[2], (i % 2) ? 5'h1F : 5'h03);
        end

        // Reset mid-stream with two entries buffered
        selLoad = 1; selIn = 3; outReady = 0; inValid = 1;
        step(); step();
        chk("lit_two_buffered", 0, inReady[0], 0);
        #2 rstN = 1'b0;
        #1 checkResetValues();
        modelReset();
        selLoad = 0; selIn = 2; inValid = 0; outReady = 1;
        @(negedge clk); @(negedge clk);
        rstN = 1'b1;
        inValid = 1;
        step();
        chk("lit_post_rst_sel0", 0, outData[0], 5'h03);
        inValid = 0;
        step();
        chk("lit_no_stale", 0, outValid[0], 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            selLoad  = ($urandom_range(0, 3) == 0);
            selIn    = 2'($urandom_range(0, 3));
            inValid  = ($urandom_range(0, 3) != 0);
            outReady = ($urandom_range(0, 3) != 0);
            errClr   = ($urandom_range(0, 7) == 0);
            inData   = 20'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_nto1_reg.md
# mux_nto1_reg

Parametrised, registered N-to-1 selector with a latched select, valid/ready flow control and illegal-select detection. It is the general successor to the fixed 5-bit 4:1 selectors in the multicycle datapath, such as register-destination and write-back source selection. The control FSM loads a select once per instruction phase, and the datapath streams operands through. Output is buffered by a 2-entry skid stage so downstream stalls never drop a selected word.

## Interface
- `WIDTH`, 5: data width per input.
- `NUM_IN`, 4: number of inputs, 2..16; need not be a power of two.
- `SEL_W`, `mux_pkg::sel_width(NUM_IN)`: select width, minimum 1.
- `LOCK_SEL`, 1: 1 = use the latched select register; 0 = use `sel_in` directly each transfer.
- `DEFAULT_VAL`, 0: value emitted for an illegal select.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sel_load`  in  1  capture `sel_in` into the select register.
- `sel_in`  in  SEL_W  new select value.
- `in_data`  in  NUM_IN*WIDTH  input i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_valid`  in  1  producer has a transfer.
- `in_ready`  out  1  block can accept.
- `out_data`  out  WIDTH  head of the skid buffer.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts.
- `sel_cur`  out  SEL_W  current latched select.
- `err_sel`  out  1  sticky illegal-select flag.
- `err_clr`  in  1  clears `err_sel`.

## Operation
- Effective select `es`:
  - `LOCK_SEL=1`: `es = sel_load ? sel_in : sel_q`. A load applies to a transfer in the same cycle (bypass).
  - `LOCK_SEL=0`: `es = sel_in`; `sel_q` still loads for `sel_cur` visibility.
- Accept occurs when `in_valid && in_ready`. The selected word `in_data[es*WIDTH +: WIDTH]` is pushed into the buffer.
- Illegal select is `es >= NUM_IN`, evaluated only on accept. The block then pushes `DEFAULT_VAL` and sets `err_sel` next cycle.
- `err_sel` holds until `err_clr`. If set and clear occur in the same cycle, set wins.
- Skid buffer: 2 entries, FIFO order, count in 0..2.
  - `in_ready = (count != 2)`.
  - `out_valid = (count != 0)`.
  - `out_data` is the head entry.
- Push and pop in the same cycle with count 1: count stays 1, and the new word becomes head next cycle.
- At count 2, `in_ready=0`. A pop that cycle makes `in_ready=1` in the following cycle; there is no combinational ready from `out_ready`.
- `sel_load` with `in_valid=0` only updates `sel_q`; nothing is pushed.

## Timing
- Reset values while `rst_n=0`, applied immediately (async):
  - `sel_q=0`, `sel_cur=0`.
  - count=0, so `out_valid=0` and `in_ready=1`.
  - `out_data=0`, `err_sel=0`.
- Latency: accept at edge N gives `out_valid=1` with the word after edge N, visible in cycle N+1.
- Throughput: 1 word/cycle while `out_ready=1`.
- `out_data` and `out_valid` are stable while `out_valid && !out_ready`.
- Reset mid-operation discards buffered entries and clears the error flag. The first transfer after deassertion uses select 0 unless `sel_load` is asserted.

## Structure
- `mux_pkg` holds:
  - `sel_width(n)` function, returning clog2 with minimum 1.
  - `MUX_MAX_IN = 16` constant.
- Sub-module `mux_skid_buf` is a 2-entry valid/ready buffer parametrised by `WIDTH` with async active-low reset.
- The top level contains the select register, the index/illegal-select logic and the error flag.

## Test plan
- Default params, `LOCK_SEL=1`, inputs 0x03/0x1F/0x0A/0x11:
  - `sel_load` with `sel_in=2`, then 3 transfers -> `out_data=0x0A` ×3, each 1 cycle after accept.
- Same-cycle `sel_load` with `sel_in=1` plus `in_valid` -> output 0x1F; `sel_cur=1` next cycle.
- `NUM_IN=3`, `sel_in=3`, accept:
  - -> `out_data=DEFAULT_VAL` and `err_sel=1`.
  - `err_clr` together with another illegal accept -> `err_sel` stays 1.
  - `err_clr` alone -> 0.
- Hold `out_ready=0` and push 3 words:
  - -> `in_ready` drops after 2, and the buffer keeps order 1, 2.
  - Release `out_ready` -> word 3 is accepted the cycle after the first pop.
- `LOCK_SEL=0`, `sel_in` toggling 0/1 each cycle, continuous valid/ready -> the output alternates 0x03/0x1F at full rate.
- Assert `rst_n=0` mid-stream with 2 entries buffered -> `out_valid=0`, `out_data=0`, `err_sel=0`, `sel_cur=0` immediately, with no stale word after release.
